circular_fifo: RTL and testbench

//  Parametrised single-clock circular FIFO; successor to the first-generation buffer.

---
 rtl/circular_fifo_pkg.sv | 22 ++
 rtl/circular_fifo_if.sv | 32 +++
 rtl/circular_fifo_ptr.sv | 35 +++
 rtl/circular_fifo.sv | 143 ++++++++++++++
 tb/tb_circular_fifo.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/circular_fifo_pkg.sv
// Shared sizing helpers for the circular FIFO and its pointer sub-module.
// Configuration macro used by the top: CIRCULAR_FIFO_ERROR_FLAGS_EN.
package circular_fifo_pkg;

  localparam int DefNSize  = 3;
  localparam int DefNWidth = 8;

  // Entries held by a FIFO with an NSize-bit address.
  function automatic int depthOf(input int nsize);
    return 1 << nsize;
  endfunction

  // Counts run 0..D inclusive, so they need one bit more than the pointers.
  function automatic int cntWidth(input int nsize);
    return nsize + 1;
  endfunction

  typedef logic [DefNSize:0]    def_count_t;
  typedef logic [DefNSize-1:0]  def_ptr_t;
  typedef logic [DefNWidth-1:0] def_data_t;

endpackage

// File: rtl/circular_fifo_if.sv
// Valid/ready handshake bundle for both sides of the circular FIFO.
// master = the surrounding producer/consumer logic, slave = the FIFO itself.
interface circular_fifo_if #(
  parameter int NWidth = 8
);

  logic              inValid;
  logic              inReady;
  logic [NWidth-1:0] inData;
  logic              outValid;
  logic              outReady;
  logic [NWidth-1:0] outData;

  modport master (
    output inValid,
    output inData,
    output outReady,
    input  inReady,
    input  outValid,
    input  outData
  );

  modport slave (
    input  inValid,
    input  inData,
    input  outReady,
    output inReady,
    output outValid,
    output outData
  );

endinterface

// File: rtl/circular_fifo_ptr.sv
// NSize-bit wrapping pointer with synchronous clear and increment.
// Wrap happens naturally through modular addition; clear wins over inc.
module circular_fifo_ptr #(
  parameter int NSize = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [NSize-1:0] ptr_o
);

  logic [NSize-1:0] ptr_q;
  logic [NSize-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/circular_fifo.sv
// Single-clock circular FIFO using all 2**NSize entries; first-word fall-through output.
// Optional sticky overflow/underflow flags under CIRCULAR_FIFO_ERROR_FLAGS_EN.
module circular_fifo
  import circular_fifo_pkg::*;
#(
  parameter int NSize  = 3,
  parameter int NWidth = 8,
  parameter int AFull  = 6,
  parameter int AEmpty = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  circular_fifo_if.slave     bus,
  output logic [NSize:0]     count,
  output logic [NSize:0]     free,
  output logic               almostFull,
  output logic               almostEmpty,
  output logic               overflow,
  output logic               underflow
);

  localparam int             Depth   = depthOf(NSize);
  localparam int             CntW    = cntWidth(NSize);
  localparam logic [NSize:0] DepthC  = CntW'(Depth);
  localparam logic [NSize:0] AFullC  = CntW'(AFull);
  localparam logic [NSize:0] AEmptyC = CntW'(AEmpty);

  logic [NWidth-1:0] mem_q [Depth];
  logic [NSize-1:0]  rd_ptr;
  logic [NSize-1:0]  wr_ptr;
  logic [NSize:0]    count_q;
  logic [NSize:0]    count_d;
  logic [NWidth-1:0] last_q;
  logic [NWidth-1:0] last_d;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic [NWidth-1:0] head;

  // Full/empty come from the count only, so pointer equality never needs disambiguating.
  assign in_ready  = (count_q != DepthC);
  assign out_valid = (count_q != '0);
  assign push      = bus.inValid & in_ready & ~flush;
  assign pop       = out_valid & bus.outReady & ~flush;
  assign head      = mem_q[rd_ptr];

  circular_fifo_ptr #(.NSize(NSize)) u_rd_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (pop),
    .ptr_o   (rd_ptr)
  );

  circular_fifo_ptr #(.NSize(NSize)) u_wr_ptr (
    .clock   (clock),
    .reset   (reset),
    .clear_i (flush),
    .inc_i   (push),
    .ptr_o   (wr_ptr)
  );

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem_q[wr_ptr] <= bus.inData;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Remembers the most recently popped word so outData holds steady while empty.
  always_comb begin
    last_d = last_q;
    if (flush) begin
      last_d = '0;
    end else if (pop) begin
      last_d = head;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      last_q  <= '0;
    end else begin
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.outData  = out_valid ? head : last_q;

  assign count       = count_q;
  assign free        = DepthC - count_q;
  assign almostFull  = (count_q >= AFullC);
  assign almostEmpty = (count_q <= AEmptyC);

`ifdef CIRCULAR_FIFO_ERROR_FLAGS_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (bus.inValid & ~in_ready);
    underflow_d = underflow_q | (bus.outReady & ~out_valid);
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_circular_fifo.sv
// Directed self-checking bench for circular_fifo (NSize=3, NWidth=8, AFull=6, AEmpty=1).
module tb_circular_fifo;

  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] count;
  logic [3:0] free;
  logic       almostFull;
  logic       almostEmpty;
  logic       overflow;
  logic       underflow;

  int n_assert;
  int n_fail;

`ifdef CIRCULAR_FIFO_ERROR_FLAGS_EN
  localparam int FlagsOn = 1;
`else
  localparam int FlagsOn = 0;
`endif

  circular_fifo_if #(.NWidth(8)) bus ();

  circular_fifo #(
    .NSize  (3),
    .NWidth (8),
    .AFull  (6),
    .AEmpty (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .bus         (bus),
    .count       (count),
    .free        (free),
    .almostFull  (almostFull),
    .almostEmpty (almostEmpty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset        = 1'b1;
    flush        = 1'b0;
    bus.inValid  = 1'b0;
    bus.inData   = 8'h00;
    bus.outReady = 1'b0;

    // Reset
    step();
    step();
    check("rst_count", 32'(count), 0);
    check("rst_free", 32'(free), 8);
    check("rst_inReady", 32'(bus.inReady), 1);
    check("rst_outValid", 32'(bus.outValid), 0);
    check("rst_outData", 32'(bus.outData), 0);
    check("rst_almostEmpty", 32'(almostEmpty), 1);
    check("rst_almostFull", 32'(almostFull), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_underflow", 32'(underflow), 0);
    reset = 1'b0;
    step();

    // Fill 01..08
    for (int i = 1; i <= 8; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 8'(i);
      step();
      check("fill_count", 32'(count), 32'(i));
      check("fill_free", 32'(free), 32'(8 - i));
      check("fill_almostFull", 32'(almostFull), 32'(i >= 6));
      check("fill_almostEmpty", 32'(almostEmpty), 32'(i <= 1));
    end
    check("full_inReady", 32'(bus.inReady), 0);
    check("full_outValid", 32'(bus.outValid), 1);
    check("full_head", 32'(bus.outData), 32'h01);

    // Push attempt while full: blocked, overflow sticks when enabled
    bus.inData = 8'hEE;
    step();
    check("ovf_count", 32'(count), 8);
    check("ovf_flag", 32'(overflow), 32'(FlagsOn));

    // Full with simultaneous pop: pop only
    bus.outReady = 1'b1;
    step();
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    check("fullpop_count", 32'(count), 7);
    check("fullpop_head", 32'(bus.outData), 32'h02);
    check("fullpop_ovf_sticky", 32'(overflow), 32'(FlagsOn));

    // Drain 02..08; EE must not appear
    for (int i = 2; i <= 8; i++) begin
      check("drain_data", 32'(bus.outData), 32'(i));
      check("drain_valid", 32'(bus.outValid), 1);
      bus.outReady = 1'b1;
      step();
      bus.outReady = 1'b0;
    end
    check("empty_outValid", 32'(bus.outValid), 0);
    check("empty_count", 32'(count), 0);
    check("empty_hold", 32'(bus.outData), 32'h08);
    check("empty_almostEmpty", 32'(almostEmpty), 1);

    // Pop attempt while empty: ignored, underflow sticks when enabled
    bus.outReady = 1'b1;
    step();
    bus.outReady = 1'b0;
    check("udf_count", 32'(count), 0);
    check("udf_flag", 32'(underflow), 32'(FlagsOn));
    check("udf_hold", 32'(bus.outData), 32'h08);

    // Preload 10..13, then 20 cycles of push+pop across pointer wrap
    for (int i = 0; i < 4; i++) begin
      bus.inValid = 1'b1;
      bus.inData  = 8'(8'h10 + i);
      step();
    end
    check("pre_count", 32'(count), 4);
    for (int k = 0; k < 20; k++) begin
      check("pp_head", 32'(bus.outData), (k < 4) ? 32'(8'h10 + k) : 32'(8'h20 + k - 4));
      bus.inValid  = 1'b1;
      bus.inData   = 8'(8'h20 + k);
      bus.outReady = 1'b1;
      step();
      check("pp_count", 32'(count), 4);
    end
    bus.outReady = 1'b0;
    bus.inData   = 8'h34;
    step();
    bus.inValid = 1'b0;
    check("pre_flush_count", 32'(count), 5);
    check("pre_flush_head", 32'(bus.outData), 32'h30);

    // Flush mid-stream with push and pop requested
    flush        = 1'b1;
    bus.inValid  = 1'b1;
    bus.inData   = 8'h77;
    bus.outReady = 1'b1;
    step();
    flush        = 1'b0;
    bus.outReady = 1'b0;
    check("flush_count", 32'(count), 0);
    check("flush_free", 32'(free), 8);
    check("flush_outValid", 32'(bus.outValid), 0);
    check("flush_outData", 32'(bus.outData), 0);
    check("flush_overflow", 32'(overflow), 0);
    check("flush_underflow", 32'(underflow), 0);

    // First push after flush appears one cycle later
    bus.inData = 8'h5A;
    step();
    bus.inValid = 1'b0;
    check("post_flush_valid", 32'(bus.outValid), 1);
    check("post_flush_data", 32'(bus.outData), 32'h5A);
    check("post_flush_count", 32'(count), 1);
    bus.outReady = 1'b1;
    step();
    bus.outReady = 1'b0;
    check("last_pop_count", 32'(count), 0);
    check("last_pop_valid", 32'(bus.outValid), 0);
    check("last_pop_hold", 32'(bus.outData), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
